// File: rtl/reaction_ctrl.sv
// Reaction-time tester: random pre-stimulus delay, ms-resolution BCD measurement,
// early/timeout fault detection and a best-time register.
module reaction_ctrl #(
    parameter int          TICK_DIV     = 50000,
    parameter int          MIN_DELAY_MS = 2000,
    parameter int          RND_W        = 11,
    parameter int          TIMEOUT_MS   = 1000,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        start,
    input  logic        stop,
    output logic        led,
    output logic        busy,
    output logic        early,
    output logic        timeout,
    output logic        done_tick,
    output logic [15:0] result_bcd,
    output logic [15:0] best_bcd,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_RND = 3'd1,
        MEASURE  = 3'd2,
        SHOW     = 3'd3,
        FAULT    = 3'd4
    } state_t;

    function automatic logic [15:0] to_bcd(input int value);
        logic [15:0] res;
        int          rem;
        res = 16'h0000;
        rem = value;
        for (int i = 0; i < 4; i++) begin
            res[4*i +: 4] = 4'(rem % 10);
            rem = rem / 10;
        end
        return res;
    endfunction

    // Ripple a +1 through four decimal digits.
    function automatic logic [15:0] bcd_inc(input logic [15:0] value);
        logic [15:0] res;
        logic        carry;
        res   = value;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (value[4*i +: 4] == 4'd9) begin
                    res[4*i +: 4] = 4'd0;
                end else begin
                    res[4*i +: 4] = value[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return res;
    endfunction

    localparam int          PW          = $clog2(TICK_DIV);
    localparam int          DW          = $clog2(MIN_DELAY_MS + (1 << RND_W) + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [15:0] TIMEOUT_BCD = to_bcd(TIMEOUT_MS);
    localparam logic [15:0] BEST_INIT   = 16'h9999;

    state_t        cur, nxt;
    logic [15:0]   lfsr, lfsr_n;
    logic [PW-1:0] presc, presc_n;
    logic [DW-1:0] ms_cnt, ms_cnt_n, ms_inc;
    logic [DW-1:0] delay, delay_n;
    logic          led_n, busy_n, early_n, timeout_n, done_tick_n;
    logic [15:0]   result_n, best_n, result_inc;
    logic          tick;

    assign state = cur;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur        <= IDLE;
            lfsr       <= SEED;
            presc      <= '0;
            ms_cnt     <= '0;
            delay      <= '0;
            led        <= 1'b0;
            busy       <= 1'b0;
            early      <= 1'b0;
            timeout    <= 1'b0;
            done_tick  <= 1'b0;
            result_bcd <= 16'h0000;
            best_bcd   <= BEST_INIT;
        end else begin
            cur        <= nxt;
            lfsr       <= lfsr_n;
            presc      <= presc_n;
            ms_cnt     <= ms_cnt_n;
            delay      <= delay_n;
            led        <= led_n;
            busy       <= busy_n;
            early      <= early_n;
            timeout    <= timeout_n;
            done_tick  <= done_tick_n;
            result_bcd <= result_n;
            best_bcd   <= best_n;
        end
    end

    always_comb begin
        nxt         = cur;
        lfsr_n      = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        presc_n     = '0;
        ms_cnt_n    = ms_cnt;
        delay_n     = delay;
        led_n       = led;
        early_n     = early;
        timeout_n   = timeout;
        done_tick_n = 1'b0;
        result_n    = result_bcd;
        best_n      = best_bcd;
        tick        = (presc == PRESC_LAST);
        ms_inc      = ms_cnt + 1'b1;
        result_inc  = bcd_inc(result_bcd);

        if (clear) begin
            nxt       = IDLE;
            ms_cnt_n  = '0;
            led_n     = 1'b0;
            early_n   = 1'b0;
            timeout_n = 1'b0;
            result_n  = 16'h0000;
            best_n    = BEST_INIT;
        end else begin
            case (cur)
                IDLE, SHOW, FAULT: begin
                    if (start) begin
                        nxt       = WAIT_RND;
                        delay_n   = DW'(MIN_DELAY_MS) + DW'(lfsr[RND_W-1:0]);
                        ms_cnt_n  = '0;
                        early_n   = 1'b0;
                        timeout_n = 1'b0;
                        result_n  = 16'h0000;
                    end
                end
                WAIT_RND: begin
                    presc_n = tick ? '0 : presc + 1'b1;
                    // A press before the light always wins over the delay expiring.
                    if (stop) begin
                        nxt     = FAULT;
                        early_n = 1'b1;
                        led_n   = 1'b0;
                    end else if (tick) begin
                        ms_cnt_n = ms_inc;
                        if (ms_inc >= delay) begin
                            nxt      = MEASURE;
                            presc_n  = '0;
                            led_n    = 1'b1;
                            result_n = 16'h0000;
                        end
                    end
                end
                MEASURE: begin
                    presc_n = tick ? '0 : presc + 1'b1;
                    if (stop) begin
                        nxt         = SHOW;
                        led_n       = 1'b0;
                        done_tick_n = 1'b1;
                        if (result_bcd < best_bcd) begin
                            best_n = result_bcd;
                        end
                    end else if (tick) begin
                        if (result_inc == TIMEOUT_BCD) begin
                            nxt       = FAULT;
                            timeout_n = 1'b1;
                            led_n     = 1'b0;
                        end
                        result_n = result_inc;
                    end
                end
                default: begin
                    nxt   = IDLE;
                    led_n = 1'b0;
                end
            endcase
        end

        busy_n = (nxt == WAIT_RND) || (nxt == MEASURE);
    end

endmodule

// File: tb/tb_reaction_ctrl.sv
// Self-checking bench for reaction_ctrl with a small ms-level reference model.
module tb_reaction_ctrl;

    localparam int TD  = 4;
    localparam int TO  = 10;
    localparam int TO2 = 1500;
    localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_MEAS = 3'd2, S_SHOW = 3'd3, S_FAULT = 3'd4;

    logic        clk = 1'b0;
    logic        reset, clear, start, stop, start2, stop2;
    logic        led, busy, early, timeout, done_tick;
    logic [15:0] result_bcd, best_bcd;
    logic [2:0]  state;
    logic        led2, busy2, early2, timeout2, done_tick2;
    logic [15:0] result_bcd2, best_bcd2;
    logic [2:0]  state2;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int led_cnt = 0;
    int exp_best = 9999;

    reaction_ctrl #(.TICK_DIV(TD), .MIN_DELAY_MS(2), .RND_W(2), .TIMEOUT_MS(TO)) dut (
        .clk(clk), .reset(reset), .clear(clear), .start(start), .stop(stop),
        .led(led), .busy(busy), .early(early), .timeout(timeout), .done_tick(done_tick),
        .result_bcd(result_bcd), .best_bcd(best_bcd), .state(state)
    );

    reaction_ctrl #(.TICK_DIV(TD), .MIN_DELAY_MS(2), .RND_W(2), .TIMEOUT_MS(TO2)) dut2 (
        .clk(clk), .reset(reset), .clear(clear), .start(start2), .stop(stop2),
        .led(led2), .busy(busy2), .early(early2), .timeout(timeout2), .done_tick(done_tick2),
        .result_bcd(result_bcd2), .best_bcd(best_bcd2), .state(state2)
    );

    // clock / reset / watchdog
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done_tick === 1'b1) done_cnt++;
        if (led === 1'b1) led_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          x;
        r = 16'h0;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // driver tasks
    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        exp_best = 9999;
    endtask

    task automatic press_stop();
        stop = 1'b1;
        @(negedge clk); stop = 1'b0;
    endtask

    task automatic hold(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Negedges from WAIT_RND entry until led is seen high.
    task automatic wait_led(output int n, output bit ok);
        n = 0;
        while (led !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = (led === 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1; clear = 0; start = 0; stop = 0; start2 = 0; stop2 = 0;
        hold(3);
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state, S_IDLE); end
        checks++; if ({led, busy, early, timeout, done_tick} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {led, busy, early, timeout, done_tick}); end
        checks++; if (result_bcd !== 16'h0000) begin errors++; $display("FAIL reset_result: got %h expected 0000", result_bcd); end
        checks++; if (best_bcd !== 16'h9999) begin errors++; $display("FAIL reset_best: got %h expected 9999", best_bcd); end
        reset = 1'b0;
        hold(2);
        checks++; if (state !== S_IDLE || busy !== 1'b0) begin errors++; $display("FAIL reset_release: state %0d busy %b expected IDLE/0", state, busy); end
    endtask

    task automatic test_valid();
        int n; bit ok;
        done_cnt = 0;
        do_start();
        checks++; if (state !== S_WAIT || busy !== 1'b1) begin errors++; $display("FAIL valid_wait: state %0d busy %b expected %0d/1", state, busy, S_WAIT); end
        wait_led(n, ok);
        checks++; if (!ok || n % TD != 0 || n / TD < 2 || n / TD > 5) begin errors++; $display("FAIL valid_delay: got %0d cycles expected 2..5 ms multiple of %0d", n, TD); end
        hold(3 * TD);
        press_stop();
        checks++; if (done_tick !== 1'b1) begin errors++; $display("FAIL valid_done_pulse: got %b expected 1", done_tick); end
        hold(1);
        if (3 < exp_best) exp_best = 3;
        checks++; if (result_bcd !== 16'h0003) begin errors++; $display("FAIL valid_result: got %h expected 0003", result_bcd); end
        checks++; if (best_bcd !== to_bcd(exp_best)) begin errors++; $display("FAIL valid_best: got %h expected %h", best_bcd, to_bcd(exp_best)); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL valid_done_count: got %0d expected 1", done_cnt); end
        checks++; if (led !== 1'b0 || state !== S_SHOW || busy !== 1'b0) begin errors++; $display("FAIL valid_end: led %b state %0d busy %b expected 0/%0d/0", led, state, busy, S_SHOW); end
    endtask

    task automatic test_early();
        done_cnt = 0; led_cnt = 0;
        do_start();
        press_stop();
        hold(30);
        checks++; if (early !== 1'b1 || timeout !== 1'b0) begin errors++; $display("FAIL early_flags: early %b timeout %b expected 1/0", early, timeout); end
        checks++; if (led_cnt != 0 || done_cnt != 0) begin errors++; $display("FAIL early_quiet: led cycles %0d done %0d expected 0/0", led_cnt, done_cnt); end
        checks++; if (result_bcd !== 16'h0000 || state !== S_FAULT) begin errors++; $display("FAIL early_end: result %h state %0d expected 0000/%0d", result_bcd, state, S_FAULT); end
    endtask

    task automatic test_timeout();
        int n; bit ok;
        done_cnt = 0; led_cnt = 0;
        do_start();
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL timeout_early_cleared: got %b expected 0", early); end
        wait_led(n, ok);
        hold(TO * TD + 20);
        checks++; if (!ok || led_cnt != TO * TD) begin errors++; $display("FAIL timeout_led_width: got %0d cycles expected %0d", led_cnt, TO * TD); end
        checks++; if (timeout !== 1'b1 || led !== 1'b0 || state !== S_FAULT) begin errors++; $display("FAIL timeout_end: timeout %b led %b state %0d expected 1/0/%0d", timeout, led, state, S_FAULT); end
        checks++; if (result_bcd !== to_bcd(TO)) begin errors++; $display("FAIL timeout_result: got %h expected %h", result_bcd, to_bcd(TO)); end
        checks++; if (best_bcd !== to_bcd(exp_best) || done_cnt != 0) begin errors++; $display("FAIL timeout_best: got %h done %0d expected %h/0", best_bcd, done_cnt, to_bcd(exp_best)); end
    endtask

    // One trial: either an early stop or a stop k cycles after the light, checked against the model.
    task automatic test_random();
        int n, k, off, exp_res; bit ok, is_early, valid;
        do_clear();
        for (int t = 0; t < 16; t++) begin
            done_cnt = 0;
            is_early = ($urandom_range(0, 4) == 0);
            do_start();
            if (is_early) begin
                off = $urandom_range(0, 5);
                hold(off);
                press_stop();
                hold(1);
                checks++; if (early !== 1'b1 || state !== S_FAULT || result_bcd !== 16'h0 || done_cnt != 0) begin errors++; $display("FAIL rand_early[%0d]: early %b state %0d result %h done %0d", t, early, state, result_bcd, done_cnt); end
            end else begin
                k = $urandom_range(0, TO * TD + 5);
                wait_led(n, ok);
                hold(k);
                press_stop();
                hold(1);
                valid   = (k < TO * TD);
                exp_res = valid ? k / TD : TO;
                if (valid && exp_res < exp_best) exp_best = exp_res;
                checks++; if (!ok || result_bcd !== to_bcd(exp_res) || best_bcd !== to_bcd(exp_best)) begin errors++; $display("FAIL rand_result[%0d]: k %0d result %h best %h expected %h/%h", t, k, result_bcd, best_bcd, to_bcd(exp_res), to_bcd(exp_best)); end
                checks++; if (state !== (valid ? S_SHOW : S_FAULT) || timeout !== !valid || done_cnt != (valid ? 1 : 0) || led !== 1'b0) begin errors++; $display("FAIL rand_status[%0d]: k %0d state %0d timeout %b done %0d led %b", t, k, state, timeout, done_cnt, led); end
            end
        end
    endtask

    task automatic run_valid(input int k);
        int n; bit ok;
        do_start();
        wait_led(n, ok);
        hold(k);
        press_stop();
        hold(1);
        if (k / TD < exp_best) exp_best = k / TD;
    endtask

    task automatic test_best_and_clear();
        do_clear();
        run_valid(5 * TD);
        run_valid(2 * TD);
        run_valid(7 * TD);
        checks++; if (result_bcd !== 16'h0007 || best_bcd !== 16'h0002 || exp_best != 2) begin errors++; $display("FAIL best_min: result %h best %h expected 0007/0002", result_bcd, best_bcd); end
        do_clear();
        checks++; if (best_bcd !== 16'h9999 || result_bcd !== 16'h0000 || state !== S_IDLE) begin errors++; $display("FAIL clear_values: best %h result %h state %0d expected 9999/0000/0", best_bcd, result_bcd, state); end
        press_stop();
        hold(2);
        checks++; if (state !== S_IDLE || early !== 1'b0) begin errors++; $display("FAIL idle_ignores_stop: state %0d early %b expected 0/0", state, early); end
    endtask

    task automatic test_level_start();
        run_valid(TD);
        @(negedge clk); start = 1'b1;
        @(negedge clk);
        checks++; if (state !== S_WAIT || result_bcd !== 16'h0000) begin errors++; $display("FAIL level_start_show: state %0d result %h expected %0d/0000", state, result_bcd, S_WAIT); end
        hold(3);
        start = 1'b0;
        checks++; if (state !== S_WAIT) begin errors++; $display("FAIL wait_ignores_start: state %0d expected %0d", state, S_WAIT); end
        hold(100);
        checks++; if (state !== S_FAULT || timeout !== 1'b1) begin errors++; $display("FAIL level_timeout: state %0d timeout %b expected %0d/1", state, timeout, S_FAULT); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (state !== S_WAIT || timeout !== 1'b0) begin errors++; $display("FAIL level_start_fault: state %0d timeout %b expected %0d/0", state, timeout, S_WAIT); end
        press_stop();
        checks++; if (state !== S_FAULT || early !== 1'b1) begin errors++; $display("FAIL level_early: state %0d early %b", state, early); end
    endtask

    task automatic test_reset_mid();
        int n; bit ok;
        do_start();
        wait_led(n, ok);
        hold(5);
        #2 reset = 1'b1;
        #1;
        checks++; if (led !== 1'b0 || state !== S_IDLE || busy !== 1'b0 || done_tick !== 1'b0) begin errors++; $display("FAIL reset_mid_immediate: led %b state %0d busy %b done %b", led, state, busy, done_tick); end
        checks++; if (result_bcd !== 16'h0 || best_bcd !== 16'h9999 || early !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL reset_mid_values: result %h best %h early %b timeout %b", result_bcd, best_bcd, early, timeout); end
        @(negedge clk); reset = 1'b0;
        exp_best = 9999;
        @(negedge clk);
        checks++; if (state !== S_IDLE || done_tick !== 1'b0) begin errors++; $display("FAIL reset_mid_first: state %0d done %b expected 0/0", state, done_tick); end
        do_start();
        wait_led(n, ok);
        checks++; if (!ok || n % TD != 0 || n / TD < 2 || n / TD > 5) begin errors++; $display("FAIL reset_mid_delay: got %0d cycles expected 2..5 ms", n); end
        hold(2 * TD);
        press_stop();
        hold(1);
        checks++; if (result_bcd !== 16'h0002 || best_bcd !== 16'h0002 || state !== S_SHOW) begin errors++; $display("FAIL reset_mid_trial: result %h best %h state %0d expected 0002/0002/%0d", result_bcd, best_bcd, state, S_SHOW); end
    endtask

    task automatic test_bcd_carry();
        int n;
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        n = 0;
        while (led2 !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++; if (led2 !== 1'b1) begin errors++; $display("FAIL carry_led: led2 %b after %0d cycles expected 1", led2, n); end
        for (int k = 1; k <= 1000 * TD; k++) begin
            @(negedge clk);
            if (k == 9 * TD || k == 10 * TD || k == 999 * TD) begin
                checks++; if (result_bcd2 !== to_bcd(k / TD)) begin errors++; $display("FAIL carry_count_%0d: got %h expected %h", k / TD, result_bcd2, to_bcd(k / TD)); end
            end
        end
        stop2 = 1'b1;
        @(negedge clk); stop2 = 1'b0;
        hold(2);
        checks++; if (result_bcd2 !== 16'h1000 || state2 !== S_SHOW || timeout2 !== 1'b0) begin errors++; $display("FAIL carry_final: result %h state %0d timeout %b expected 1000/%0d/0", result_bcd2, state2, timeout2, S_SHOW); end
    endtask

    initial begin
        test_reset();
        test_valid();
        test_early();
        test_timeout();
        test_best_and_clear();
        test_random();
        test_level_start();
        test_reset_mid();
        test_bcd_carry();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reaction_ctrl.md
REACTION_CTRL -- requirements
Module: reaction_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, meaning clk cycles per 1 ms tick (minimum 2).
REQ-002 SHALL have parameter MIN_DELAY_MS, default 2000, meaning the fixed part of the random pre-stimulus delay.
REQ-003 SHALL have parameter RND_W, default 11, meaning the width of the random delay addend (0..2^RND_W-1 ms).
REQ-004 SHALL have parameter TIMEOUT_MS, default 1000, meaning the reaction window limit (at most 9999).
REQ-005 SHALL have parameter SEED, default 16'hACE1, meaning the non-zero LFSR reset value.
REQ-006 SHALL have port clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port clear, input, 1 bit: synchronous abort and clear of results.
REQ-009 SHALL have port start, input, 1 bit: begin a trial (level, sampled per cycle).
REQ-010 SHALL have port stop, input, 1 bit: user response (level, sampled per cycle).
REQ-011 SHALL have port led, output, 1 bit: stimulus light.
REQ-012 SHALL have port busy, output, 1 bit: high in WAIT_RND and MEASURE.
REQ-013 SHALL have port early, output, 1 bit: sticky flag for a stop pressed before the stimulus.
REQ-014 SHALL have port timeout, output, 1 bit: sticky flag for no response within TIMEOUT_MS.
REQ-015 SHALL have port done_tick, output, 1 bit: one-cycle pulse on a valid measurement.
REQ-016 SHALL have port result_bcd, output, 16 bits: last reaction time, 4 BCD digits in ms.
REQ-017 SHALL have port best_bcd, output, 16 bits: minimum valid reaction time since reset or clear, BCD.

Function
REQ-018 SHALL implement states IDLE, WAIT_RND, MEASURE, SHOW and FAULT; all outputs SHALL be registered.
REQ-019 SHALL run a 16-bit Fibonacci LFSR (taps 16,14,13,11) every cycle in all states; it is never all-zero.
REQ-020 SHALL, in IDLE or SHOW with start=1, latch delay = MIN_DELAY_MS + lfsr[RND_W-1:0], clear early/timeout/result, restart the prescaler, and enter WAIT_RND on the next edge.
REQ-021 SHALL, in FAULT with start=1, take the same action as REQ-020.
REQ-022 SHALL use a ms prescaler that restarts at 0 on entry to WAIT_RND and to MEASURE; the first ms tick occurs exactly TICK_DIV cycles after entry.
REQ-023 SHALL, in WAIT_RND, count ms ticks and, on the tick making the count equal the delay, enter MEASURE with led=1 and result=0000.
REQ-024 SHALL, in WAIT_RND with stop=1, set early=1, keep led=0 and enter FAULT; stop SHALL take priority over a same-cycle delay expiry.
REQ-025 SHALL, in MEASURE, increment result_bcd by 1 per ms tick using decimal carry per digit (0009->0010, 0999->1000).
REQ-026 SHALL, in MEASURE with stop=1, freeze result, set led=0, pulse done_tick, update best if result<best (BCD compare equals binary compare), and enter SHOW.
REQ-027 SHALL, when result reaches TIMEOUT_MS in MEASURE and stop=0, set timeout=1 and led=0, hold result=TIMEOUT_MS and enter FAULT; stop on that same cycle SHALL win and count as valid.
REQ-028 SHALL ignore stop in IDLE, SHOW and FAULT, and ignore start in WAIT_RND and MEASURE.
REQ-029 SHALL treat clear=1 in any state as highest priority: state=IDLE, led=0, flags=0, result=0000, best=9999, done_tick=0.
REQ-030 SHALL start a new trial while start is held high in SHOW or FAULT (level-sensitive, no edge detection).

Reset
REQ-031 SHALL, while reset=1, force state=IDLE, led=0, busy=0, early=0, timeout=0, done_tick=0, result_bcd=16'h0000, best_bcd=16'h9999, lfsr=SEED, and clear the prescaler and delay counters.
REQ-032 SHALL abandon any trial on reset mid-operation; the first post-reset cycle SHALL be IDLE with no done_tick.

Verification
(Parameters for all scenarios: TICK_DIV=4, MIN_DELAY_MS=2, RND_W=2, TIMEOUT_MS=10.)
REQ-033 SHALL pass: start pulse, stop after led has been high 3 ms -> result_bcd=0003, one done_tick, best=0003, led=0, state SHOW.
REQ-034 SHALL pass: start, then stop 1 cycle into WAIT_RND -> early=1, led never rises, no done_tick, result=0000.
REQ-035 SHALL pass: start, no stop -> led high for exactly 10 ms, then timeout=1, result=0010, led=0, best unchanged.
REQ-036 SHALL pass: two valid trials measuring 0005 then 0002, then one measuring 0007 -> best=0002; clear -> best=9999, result=0000.
REQ-037 SHALL pass: reset asserted mid-MEASURE -> immediate led=0 and all reset values; start afterwards runs a normal trial with delay within 2..5 ms.
REQ-038 SHALL pass: with TIMEOUT_MS=1500, a stop after 1000 ms -> result_bcd=16'h1000, verifying multi-digit BCD carry.
